// File: rtl/register_rename_unit.sv
// Dual-issue register rename stage: register alias table plus a circular
// free list of physical registers, with registered rename outputs.
module register_rename_unit #(
  parameter int NUM_A_REGS = 32,
  parameter int NUM_P_REGS = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_free_reg0_i,
  input  logic                          en_free_reg1_i,
  input  logic [$clog2(NUM_P_REGS)-1:0] free_reg0_i,
  input  logic [$clog2(NUM_P_REGS)-1:0] free_reg1_i,
  input  logic                          en_new_dest0_i,
  input  logic                          en_new_dest1_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] assign_dest0_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] assign_dest1_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] get_src10_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] get_src11_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] get_src20_i,
  input  logic [$clog2(NUM_A_REGS)-1:0] get_src21_i,
  output logic [$clog2(NUM_P_REGS)-1:0] old_dest0_o,
  output logic [$clog2(NUM_P_REGS)-1:0] old_dest1_o,
  output logic [$clog2(NUM_P_REGS)-1:0] p_dest0_o,
  output logic [$clog2(NUM_P_REGS)-1:0] p_dest1_o,
  output logic [$clog2(NUM_P_REGS)-1:0] p_src10_o,
  output logic [$clog2(NUM_P_REGS)-1:0] p_src11_o,
  output logic [$clog2(NUM_P_REGS)-1:0] p_src20_o,
  output logic [$clog2(NUM_P_REGS)-1:0] p_src21_o,
  output logic                          no_pregs_left_o
);

  localparam int AW = $clog2(NUM_A_REGS);
  localparam int PW = $clog2(NUM_P_REGS);
  localparam int CW = $clog2(NUM_P_REGS + 1);
  localparam int NFREE = NUM_P_REGS - NUM_A_REGS;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(NUM_P_REGS - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  logic [PW-1:0] rat_q [NUM_A_REGS];
  logic [PW-1:0] fl_q  [NUM_P_REGS];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [PW-1:0] old_dest0_q, old_dest0_d;
  logic [PW-1:0] old_dest1_q, old_dest1_d;
  logic [PW-1:0] p_dest0_q, p_dest0_d;
  logic [PW-1:0] p_dest1_q, p_dest1_d;
  logic [PW-1:0] p_src10_q, p_src10_d;
  logic [PW-1:0] p_src11_q, p_src11_d;
  logic [PW-1:0] p_src20_q, p_src20_d;
  logic [PW-1:0] p_src21_q, p_src21_d;

  logic          need0, need1;
  logic          alloc0, alloc1;
  logic          stall;
  logic [CW-1:0] nreq;
  logic [PW-1:0] head1;
  logic [PW-1:0] tail1;
  logic [PW-1:0] new0, new1;
  logic          acc0, acc1;
  logic          fwd11, fwd21;

  always_comb begin
    need0 = en_new_dest0_i && (assign_dest0_i != '0);
    need1 = en_new_dest1_i && (assign_dest1_i != '0);
    nreq  = CW'(need0) + CW'(need1);
    stall = nreq > count_q;
    alloc0 = need0 && !stall;
    alloc1 = need1 && !stall;
    head1 = ptr_inc(head_q);
    new0  = fl_q[head_q];
    new1  = alloc0 ? fl_q[head1] : fl_q[head_q];
  end

  // Slot 1 sources see slot 0's fresh mapping only when it really happens.
  always_comb begin
    fwd11 = alloc0 && (get_src11_i == assign_dest0_i);
    fwd21 = alloc0 && (get_src21_i == assign_dest0_i);
    p_src10_d = rat_q[get_src10_i];
    p_src20_d = rat_q[get_src20_i];
    p_src11_d = fwd11 ? new0 : rat_q[get_src11_i];
    p_src21_d = fwd21 ? new0 : rat_q[get_src21_i];
  end

  always_comb begin
    p_dest0_d   = '0;
    p_dest1_d   = '0;
    old_dest0_d = '0;
    old_dest1_d = '0;
    if (alloc0) begin
      p_dest0_d   = new0;
      old_dest0_d = rat_q[assign_dest0_i];
    end
    if (alloc1) begin
      p_dest1_d = new1;
      if (alloc0 && (assign_dest1_i == assign_dest0_i)) begin
        old_dest1_d = new0;
      end else begin
        old_dest1_d = rat_q[assign_dest1_i];
      end
    end
  end

  always_comb begin
    head_d = head_q;
    if (alloc0 && alloc1) begin
      head_d = ptr_inc(head1);
    end else if (alloc0 || alloc1) begin
      head_d = head1;
    end
  end

  // Capacity check uses the pre-edge count; pops this cycle do not make room.
  always_comb begin
    acc0 = en_free_reg0_i && (free_reg0_i != '0)
           && (count_q < CW'(NUM_P_REGS));
    acc1 = en_free_reg1_i && (free_reg1_i != '0)
           && ((count_q + CW'(acc0)) < CW'(NUM_P_REGS));
    tail1  = acc0 ? ptr_inc(tail_q) : tail_q;
    tail_d = acc1 ? ptr_inc(tail1) : tail1;
    count_d = count_q - CW'(alloc0) - CW'(alloc1)
              + CW'(acc0) + CW'(acc1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_A_REGS; i++) begin
        rat_q[i] <= PW'(i);
      end
    end else begin
      if (alloc0) begin
        rat_q[assign_dest0_i] <= new0;
      end
      if (alloc1) begin
        rat_q[assign_dest1_i] <= new1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_P_REGS; i++) begin
        fl_q[i] <= (i < NFREE) ? PW'(NUM_A_REGS + i) : '0;
      end
      head_q  <= '0;
      tail_q  <= PW'(NFREE);
      count_q <= CW'(NFREE);
    end else begin
      if (acc0) begin
        fl_q[tail_q] <= free_reg0_i;
      end
      if (acc1) begin
        fl_q[tail1] <= free_reg1_i;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      old_dest0_q <= '0;
      old_dest1_q <= '0;
      p_dest0_q   <= '0;
      p_dest1_q   <= '0;
      p_src10_q   <= '0;
      p_src11_q   <= '0;
      p_src20_q   <= '0;
      p_src21_q   <= '0;
    end else begin
      old_dest0_q <= old_dest0_d;
      old_dest1_q <= old_dest1_d;
      p_dest0_q   <= p_dest0_d;
      p_dest1_q   <= p_dest1_d;
      p_src10_q   <= p_src10_d;
      p_src11_q   <= p_src11_d;
      p_src20_q   <= p_src20_d;
      p_src21_q   <= p_src21_d;
    end
  end

  assign old_dest0_o     = old_dest0_q;
  assign old_dest1_o     = old_dest1_q;
  assign p_dest0_o       = p_dest0_q;
  assign p_dest1_o       = p_dest1_q;
  assign p_src10_o       = p_src10_q;
  assign p_src11_o       = p_src11_q;
  assign p_src20_o       = p_src20_q;
  assign p_src21_o       = p_src21_q;
  assign no_pregs_left_o = (count_q == '0);

endmodule

// File: tb/tb_register_rename_unit.sv
// Bench for register_rename_unit: directed scenarios plus random traffic
// against a queue-based alias-table/free-list reference model.
module tb_register_rename_unit;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       en_free_reg0_i, en_free_reg1_i;
  logic [5:0] free_reg0_i, free_reg1_i;
  logic       en_new_dest0_i, en_new_dest1_i;
  logic [4:0] assign_dest0_i, assign_dest1_i;
  logic [4:0] get_src10_i, get_src11_i, get_src20_i, get_src21_i;
  logic [5:0] old_dest0_o, old_dest1_o, p_dest0_o, p_dest1_o;
  logic [5:0] p_src10_o, p_src11_o, p_src20_o, p_src21_o;
  logic       no_pregs_left_o;

  register_rename_unit dut (
    .clk_i(clk), .rst_i(rst_i),
    .en_free_reg0_i(en_free_reg0_i), .en_free_reg1_i(en_free_reg1_i),
    .free_reg0_i(free_reg0_i), .free_reg1_i(free_reg1_i),
    .en_new_dest0_i(en_new_dest0_i), .en_new_dest1_i(en_new_dest1_i),
    .assign_dest0_i(assign_dest0_i), .assign_dest1_i(assign_dest1_i),
    .get_src10_i(get_src10_i), .get_src11_i(get_src11_i),
    .get_src20_i(get_src20_i), .get_src21_i(get_src21_i),
    .old_dest0_o(old_dest0_o), .old_dest1_o(old_dest1_o),
    .p_dest0_o(p_dest0_o), .p_dest1_o(p_dest1_o),
    .p_src10_o(p_src10_o), .p_src11_o(p_src11_o),
    .p_src20_o(p_src20_o), .p_src21_o(p_src21_o),
    .no_pregs_left_o(no_pregs_left_o)
  );

  always #5 clk = ~clk;

  int rat [32];
  int fl [$];
  int pending [$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rat[i] = i;
    fl.delete();
    for (int p = 32; p < 64; p++) fl.push_back(p);
    pending.delete();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_reset();
    #2;
    check("rst_nopregs", int'(no_pregs_left_o), 0);
    check("rst_pdest0", int'(p_dest0_o), 0);
    check("rst_pdest1", int'(p_dest1_o), 0);
    check("rst_old0", int'(old_dest0_o), 0);
    check("rst_src11", int'(p_src11_o), 0);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic step(input bit e0, input int d0, input bit e1, input int d1,
                      input int s10, input int s11, input int s20,
                      input int s21, input bit fe0, input int f0,
                      input bit fe1, input int f1);
    bit need0, need1, stall, a0, a1;
    int n0, n1, pre, nreq;
    int x10, x11, x20, x21, od0, od1, pd0, pd1;
    en_new_dest0_i = e0; assign_dest0_i = 5'(d0);
    en_new_dest1_i = e1; assign_dest1_i = 5'(d1);
    get_src10_i = 5'(s10); get_src11_i = 5'(s11);
    get_src20_i = 5'(s20); get_src21_i = 5'(s21);
    en_free_reg0_i = fe0; free_reg0_i = 6'(f0);
    en_free_reg1_i = fe1; free_reg1_i = 6'(f1);
    need0 = e0 && d0 != 0;
    need1 = e1 && d1 != 0;
    nreq = int'(need0) + int'(need1);
    pre = fl.size();
    stall = nreq > pre;
    n0 = 0; n1 = 0; pd0 = 0; pd1 = 0; od0 = 0; od1 = 0;
    x10 = rat[s10]; x20 = rat[s20];
    x11 = rat[s11]; x21 = rat[s21];
    if (!stall) begin
      if (need0) n0 = fl.pop_front();
      if (need1) n1 = fl.pop_front();
      if (need0) begin
        pd0 = n0; od0 = rat[d0];
        if (s11 == d0) x11 = n0;
        if (s21 == d0) x21 = n0;
      end
      if (need1) begin
        pd1 = n1;
        od1 = (need0 && d1 == d0) ? n0 : rat[d1];
      end
      if (need0) rat[d0] = n0;
      if (need1) rat[d1] = n1;
    end
    a0 = fe0 && f0 != 0 && pre < 64;
    a1 = fe1 && f1 != 0 && pre + int'(a0) < 64;
    if (a0) fl.push_back(f0);
    if (a1) fl.push_back(f1);
    if (od0 != 0) pending.push_back(od0);
    if (od1 != 0) pending.push_back(od1);
    @(posedge clk);
    #1;
    check("p_dest0", int'(p_dest0_o), pd0);
    check("p_dest1", int'(p_dest1_o), pd1);
    check("old_dest0", int'(old_dest0_o), od0);
    check("old_dest1", int'(old_dest1_o), od1);
    check("p_src10", int'(p_src10_o), x10);
    check("p_src11", int'(p_src11_o), x11);
    check("p_src20", int'(p_src20_o), x20);
    check("p_src21", int'(p_src21_o), x21);
    check("no_pregs", int'(no_pregs_left_o), int'(fl.size() == 0));
  endtask

  task automatic alloc_only(input bit e0, input int d0,
                            input bit e1, input int d1);
    step(e0, d0, e1, d1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    en_free_reg0_i = 0; en_free_reg1_i = 0;
    free_reg0_i = '0; free_reg1_i = '0;
    en_new_dest0_i = 0; en_new_dest1_i = 0;
    assign_dest0_i = '0; assign_dest1_i = '0;
    get_src10_i = '0; get_src11_i = '0;
    get_src20_i = '0; get_src21_i = '0;
    do_reset();

    step(1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    check("t1_pdest0", int'(p_dest0_o), 32);
    check("t1_pdest1", int'(p_dest1_o), 33);
    check("t1_old0", int'(old_dest0_o), 1);
    check("t1_old1", int'(old_dest1_o), 2);
    check("t1_src10", int'(p_src10_o), 1);

    step(1, 5, 1, 5, 0, 5, 0, 0, 0, 0, 0, 0);
    check("dep_src11", int'(p_src11_o), 34);
    check("dep_src21", int'(p_src21_o), 0);
    check("dep_old1", int'(old_dest1_o), 34);
    check("dep_pdest1", int'(p_dest1_o), 35);
    step(0, 0, 0, 0, 5, 5, 1, 2, 0, 0, 0, 0);
    check("dep_lookup", int'(p_src10_o), 35);

    do_reset();
    step(1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    check("x0_pdest0", int'(p_dest0_o), 0);
    alloc_only(1, 3, 0, 0);
    check("x0_next", int'(p_dest0_o), 32);

    do_reset();
    for (int k = 0; k < 16; k++) alloc_only(1, 1 + k, 1, 17 + (k % 15));
    check("exh_empty", int'(no_pregs_left_o), 1);
    step(1, 3, 1, 4, 3, 4, 0, 0, 0, 0, 0, 0);
    check("exh_stall_pd0", int'(p_dest0_o), 0);
    step(0, 0, 0, 0, 3, 4, 0, 0, 1, 7, 1, 9);
    check("rec_nonempty", int'(no_pregs_left_o), 0);
    alloc_only(1, 10, 1, 11);
    check("rec_pd0", int'(p_dest0_o), 7);
    check("rec_pd1", int'(p_dest1_o), 9);

    do_reset();
    for (int k = 0; k < 15; k++) alloc_only(1, 1 + k, 1, 16 + k);
    alloc_only(1, 31, 0, 0);
    step(1, 2, 1, 3, 2, 3, 0, 0, 0, 0, 0, 0);
    check("one_stall", int'(p_dest0_o), 0);
    alloc_only(1, 4, 0, 0);
    check("one_single", int'(p_dest0_o), 63);
    check("one_empty", int'(no_pregs_left_o), 1);

    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    check("async_nopregs", int'(no_pregs_left_o), 0);
    check("async_src10", int'(p_src10_o), 0);
    @(negedge clk);
    rst_i = 1'b0;
    step(1, 6, 0, 0, 4, 31, 2, 3, 0, 0, 0, 0);
    check("async_pd0", int'(p_dest0_o), 32);

    for (int i = 0; i < 3000; i++) begin
      bit fe0, fe1;
      int f0, f1, rate;
      rate = ((i / 300) % 2 == 0) ? 3 : 1;
      fe0 = 0; fe1 = 0; f0 = 0; f1 = 0;
      if (pending.size() > 0 && $urandom_range(3, 0) < rate) begin
        fe0 = 1; f0 = pending.pop_front();
      end
      if (pending.size() > 0 && $urandom_range(3, 0) < rate) begin
        fe1 = 1; f1 = pending.pop_front();
      end
      step($urandom_range(3, 0) != 0, $urandom_range(31, 0),
           $urandom_range(3, 0) != 0, $urandom_range(31, 0),
           $urandom_range(31, 0), $urandom_range(31, 0),
           $urandom_range(31, 0), $urandom_range(31, 0),
           fe0, f0, fe1, f1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
